// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Architectural x0: never stored, never marked, always reads as zero.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for long-latency results, plus a registered
// count of busy registers maintained incrementally.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     mark_en_i,
  input  logic [ADDR_W-1:0]        mark_addr_i,
  output logic [NUM_REGS-1:0]      busy_o,
  output logic [CNT_W-1:0]         busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_vec, set_vec;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    dec;
  logic                inc;
  logic [ADDR_W-1:0]   wa;

  // Clears from write-back, then a same-cycle mark wins so a fresh issue
  // supersedes the result being retired.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    wa      = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa = wr_addr_i[w*ADDR_W +: ADDR_W];
      if (wr_en_i[w] && (wa != ADDR_W'(ZERO_REG))) clr_vec[wa] = 1'b1;
    end
    if (mark_en_i && (mark_addr_i != ADDR_W'(ZERO_REG))) set_vec[mark_addr_i] = 1'b1;
    busy_d = (busy_q & ~clr_vec) | set_vec;

    // Count moves by +1 for a mark on an idle register, and -1 for each
    // distinct busy register retired without being re-marked.
    inc = |(set_vec & ~busy_q);
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (busy_q[i] && clr_vec[i] && !set_vec[i]) dec = dec + CNT_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(inc) - dec;
  end

  // Busy vector and count registers; reset discards any pending marks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage with write-port priority, optional
// same-cycle write-to-read bypass, and a busy scoreboard for decode stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic                     i_mark_en,
  input  logic [ADDR_W-1:0]        i_mark_addr,
  output logic [CNT_W-1:0]         o_busy_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W-1:0]   wa;
  logic [ADDR_W-1:0]   ra;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .wr_en_i     (i_wr_en),
    .wr_addr_i   (i_wr_addr),
    .mark_en_i   (i_mark_en),
    .mark_addr_i (i_mark_addr),
    .busy_o      (busy),
    .busy_cnt_o  (o_busy_cnt)
  );

  // Next storage contents: ports applied in index order so the later
  // pipeline stage (higher index) wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    wa     = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa = i_wr_addr[w*ADDR_W +: ADDR_W];
      if (i_wr_en[w] && (wa != ADDR_W'(ZERO_REG))) regs_d[wa] = i_wr_data[w*DATA_W +: DATA_W];
    end
  end

  // Storage array; x0 is never written so it stays zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: stored value and busy bit, overridden by the highest-index
  // matching write when bypass is enabled (a forwarded result is not busy;
  // a same-cycle mark only lands at the edge). x0 always reads 0, not busy.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    ra        = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = i_rd_addr[r*ADDR_W +: ADDR_W];
      o_rd_data[r*DATA_W +: DATA_W] = regs_q[ra];
      o_rd_busy[r]                  = busy[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_wr_en[w] && (i_wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
            o_rd_data[r*DATA_W +: DATA_W] = i_wr_data[w*DATA_W +: DATA_W];
            o_rd_busy[r]                  = 1'b0;
          end
        end
      end
      if (ra == ADDR_W'(ZERO_REG)) begin
        o_rd_data[r*DATA_W +: DATA_W] = '0;
        o_rd_busy[r]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A uses the default configuration
// (32-bit, 2R/2W, bypass on); instance B is 64-bit, 4R/1W, bypass off.
// Both are checked against an array-based model of the register file.
module tb_regfile_mp;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  // ---------------- instance A signals ----------------
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_mark_en;
  logic [4:0]  a_mark_addr;
  logic [5:0]  a_cnt;

  // ---------------- instance B signals ----------------
  logic [19:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [4:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_mark_en;
  logic [4:0]   b_mark_addr;
  logic [5:0]   b_cnt;

  regfile_mp dut_a (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_addr   (a_rd_addr),
    .o_rd_data   (a_rd_data),
    .o_rd_busy   (a_rd_busy),
    .i_wr_en     (a_wr_en),
    .i_wr_addr   (a_wr_addr),
    .i_wr_data   (a_wr_data),
    .i_mark_en   (a_mark_en),
    .i_mark_addr (a_mark_addr),
    .o_busy_cnt  (a_cnt)
  );

  regfile_mp #(
    .DATA_W (64),
    .NUM_RD (4),
    .NUM_WR (1),
    .BYPASS (0)
  ) dut_b (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_addr   (b_rd_addr),
    .o_rd_data   (b_rd_data),
    .o_rd_busy   (b_rd_busy),
    .i_wr_en     (b_wr_en),
    .i_wr_addr   (b_wr_addr),
    .i_wr_data   (b_wr_data),
    .i_mark_en   (b_mark_en),
    .i_mark_addr (b_mark_addr),
    .o_busy_cnt  (b_cnt)
  );

  // ---------------- reference model ----------------
  // Index 0 = instance A, index 1 = instance B.
  logic [63:0] m_reg  [2][32];
  bit          m_busy [2][32];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int pop(input int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
    return c;
  endfunction

  // A read as seen this cycle, with bypass rules applied.
  task automatic exp_a(input logic [4:0] ad, output logic [63:0] d, output logic b);
    d = m_reg[0][ad];
    b = m_busy[0][ad];
    for (int w = 0; w < 2; w++) begin
      if (a_wr_en[w] && (a_wr_addr[w*5 +: 5] == ad)) begin
        d = {32'h0, a_wr_data[w*32 +: 32]};
        b = 1'b0;
      end
    end
    if (ad == 5'd0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  task automatic check_reads();
    logic [63:0] d;
    logic        b;
    logic [4:0]  ad;
    for (int p = 0; p < 2; p++) begin
      ad = a_rd_addr[p*5 +: 5];
      exp_a(ad, d, b);
      chk($sformatf("a_rd_data[%0d] x%0d", p, ad), {32'h0, a_rd_data[p*32 +: 32]}, d);
      chk($sformatf("a_rd_busy[%0d] x%0d", p, ad), {63'h0, a_rd_busy[p]}, {63'h0, b});
    end
    for (int p = 0; p < 4; p++) begin
      ad = b_rd_addr[p*5 +: 5];
      d  = (ad == 5'd0) ? 64'h0 : m_reg[1][ad];
      b  = (ad == 5'd0) ? 1'b0 : m_busy[1][ad];
      chk($sformatf("b_rd_data[%0d] x%0d", p, ad), b_rd_data[p*64 +: 64], d);
      chk($sformatf("b_rd_busy[%0d] x%0d", p, ad), {63'h0, b_rd_busy[p]}, {63'h0, b});
    end
  endtask

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_edge();
    logic [4:0] ad;
    if (i_rst) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          m_reg[k][i]  = '0;
          m_busy[k][i] = 1'b0;
        end
    end else begin
      for (int w = 0; w < 2; w++) begin
        ad = a_wr_addr[w*5 +: 5];
        if (a_wr_en[w] && ad != 5'd0) begin
          m_reg[0][ad]  = {32'h0, a_wr_data[w*32 +: 32]};
          m_busy[0][ad] = 1'b0;
        end
      end
      if (a_mark_en && a_mark_addr != 5'd0) m_busy[0][a_mark_addr] = 1'b1;
      if (b_wr_en[0] && b_wr_addr != 5'd0) begin
        m_reg[1][b_wr_addr]  = b_wr_data;
        m_busy[1][b_wr_addr] = 1'b0;
      end
      if (b_mark_en && b_mark_addr != 5'd0) m_busy[1][b_mark_addr] = 1'b1;
    end
  endtask

  // One cycle: check combinational reads, take the edge, check counts.
  task automatic cycle(input bit pre);
    if (pre) begin
      #2;
      check_reads();
    end
    @(posedge i_clk);
    model_edge();
    #1;
    chk("a_busy_cnt", {58'h0, a_cnt}, 64'(pop(0)));
    chk("b_busy_cnt", {58'h0, b_cnt}, 64'(pop(1)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    i_rst       = 1'b0;
    a_wr_en     = '0;
    a_wr_addr   = '0;
    a_wr_data   = '0;
    a_mark_en   = 1'b0;
    a_mark_addr = '0;
    a_rd_addr   = '0;
    b_wr_en     = '0;
    b_wr_addr   = '0;
    b_wr_data   = '0;
    b_mark_en   = 1'b0;
    b_mark_addr = '0;
    b_rd_addr   = '0;
  endtask

  task automatic wa(input int port, input int ad, input logic [31:0] d);
    a_wr_en[port]           = 1'b1;
    a_wr_addr[port*5 +: 5]  = 5'(ad);
    a_wr_data[port*32 +: 32] = d;
  endtask

  task automatic ra(input int port, input int ad);
    a_rd_addr[port*5 +: 5] = 5'(ad);
  endtask

  task automatic ma(input int ad);
    a_mark_en   = 1'b1;
    a_mark_addr = 5'(ad);
  endtask

  task automatic wb(input int ad, input logic [63:0] d);
    b_wr_en[0] = 1'b1;
    b_wr_addr  = 5'(ad);
    b_wr_data  = d;
  endtask

  task automatic rb(input int port, input int ad);
    b_rd_addr[port*5 +: 5] = 5'(ad);
  endtask

  task automatic mb(input int ad);
    b_mark_en   = 1'b1;
    b_mark_addr = 5'(ad);
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_reg[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end

    // Reset edge, then every read returns 0 / not busy.
    idle();
    i_rst = 1'b1;
    cycle(1'b0);
    chk("cnt after reset", {58'h0, a_cnt}, 64'h0);
    idle(); ra(0, 5); ra(1, 31); rb(0, 1); rb(1, 9); rb(2, 17); rb(3, 31);
    cycle(1'b1);

    // x5 = DEADBEEF, visible next cycle.
    idle(); wa(0, 5, 32'hDEAD_BEEF);
    cycle(1'b1);
    idle(); ra(0, 5);
    #2 chk("x5 readback", {32'h0, a_rd_data[31:0]}, 64'hDEAD_BEEF);
    cycle(1'b1);

    // Writes to x0 are dropped, even through bypass.
    idle(); wa(0, 0, 32'h1234); ra(1, 0);
    #2 chk("x0 bypass read", {32'h0, a_rd_data[63:32]}, 64'h0);
    cycle(1'b1);
    idle(); ra(0, 0);
    #2 chk("x0 stored read", {32'h0, a_rd_data[31:0]}, 64'h0);
    cycle(1'b1);

    // Two ports on x7: port 1 wins; bypass only on A.
    idle(); wa(0, 7, 32'h11); wa(1, 7, 32'h22); ra(0, 7);
    wb(7, 64'h11); rb(0, 7);
    #2;
    chk("x7 bypass port1 wins", {32'h0, a_rd_data[31:0]}, 64'h22);
    chk("b x7 no bypass", b_rd_data[63:0], 64'h0);
    cycle(1'b1);
    idle(); ra(1, 7); rb(0, 7);
    #2;
    chk("x7 stored", {32'h0, a_rd_data[63:32]}, 64'h22);
    chk("b x7 stored", b_rd_data[63:0], 64'h11);
    cycle(1'b1);

    // Mark x3, then retire it with a bypassed write.
    idle(); ma(3);
    cycle(1'b1);
    chk("cnt after mark x3", {58'h0, a_cnt}, 64'h1);
    idle(); ra(0, 3);
    #2 chk("x3 busy", {63'h0, a_rd_busy[0]}, 64'h1);
    cycle(1'b1);
    idle(); wa(0, 3, 32'h55); ra(0, 3);
    #2;
    chk("x3 bypass data", {32'h0, a_rd_data[31:0]}, 64'h55);
    chk("x3 bypass busy", {63'h0, a_rd_busy[0]}, 64'h0);
    cycle(1'b1);
    chk("cnt after clear x3", {58'h0, a_cnt}, 64'h0);

    // Mark and write x9 together: data lands, busy stays set.
    idle(); ma(9); wa(1, 9, 32'h77);
    cycle(1'b1);
    chk("cnt after mark+write x9", {58'h0, a_cnt}, 64'h1);
    idle(); ra(0, 9);
    #2;
    chk("x9 data", {32'h0, a_rd_data[31:0]}, 64'h77);
    chk("x9 busy", {63'h0, a_rd_busy[0]}, 64'h1);
    cycle(1'b1);
    idle(); ma(0);
    cycle(1'b1);
    chk("cnt after mark x0", {58'h0, a_cnt}, 64'h1);

    // Marks on x1, x2, x4, then reset alongside a write to x1.
    idle(); ma(1); cycle(1'b1);
    idle(); ma(2); cycle(1'b1);
    idle(); ma(4); cycle(1'b1);
    chk("cnt before reset", {58'h0, a_cnt}, 64'h4);
    idle(); i_rst = 1'b1; wa(0, 1, 32'h99);
    cycle(1'b0);
    chk("cnt after mid reset", {58'h0, a_cnt}, 64'h0);
    idle(); ra(0, 1); ra(1, 9);
    #2;
    chk("x1 after reset", {32'h0, a_rd_data[31:0]}, 64'h0);
    chk("x9 busy after reset", {63'h0, a_rd_busy[1]}, 64'h0);
    cycle(1'b1);

    // Wide instance: mark x31, retire it with a 64-bit value, read on all ports.
    idle(); mb(31);
    cycle(1'b1);
    chk("b cnt after mark x31", {58'h0, b_cnt}, 64'h1);
    idle(); wb(31, 64'hFFFF_0000_FFFF_0000);
    cycle(1'b1);
    chk("b cnt after clear x31", {58'h0, b_cnt}, 64'h0);
    idle();
    for (int p = 0; p < 4; p++) rb(p, 31);
    #2;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b x31 port%0d data", p), b_rd_data[p*64 +: 64], 64'hFFFF_0000_FFFF_0000);
      chk($sformatf("b x31 port%0d busy", p), {63'h0, b_rd_busy[p]}, 64'h0);
    end
    cycle(1'b1);

    // Randomised traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      idle();
      i_rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        ra(p, rnd_addr());
        if ($urandom_range(0, 2) == 0) wa(p, rnd_addr(), $urandom);
      end
      if ($urandom_range(0, 2) == 0) ma(rnd_addr());
      for (int p = 0; p < 4; p++) rb(p, rnd_addr());
      if ($urandom_range(0, 2) == 0) wb(rnd_addr(), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) mb(rnd_addr());
      cycle(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
